// File: rtl/arb_pkg.sv
// arb_pkg -- shared definitions for the three-way round-robin arbiter.
//   state_t         : arbiter FSM states (IDLE, BUSY, GAP)
//   CODE_*          : grant_code values for each requester and for "no grant"
//   rr_pick()       : first set request bit searching upward from a pointer, mod 3
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  localparam logic [1:0] CODE_R0   = 2'b00;
  localparam logic [1:0] CODE_R1   = 2'b01;
  localparam logic [1:0] CODE_R2   = 2'b10;
  localparam logic [1:0] CODE_NONE = 2'b11;

  // Returns the index of the first asserted request starting at ptr and
  // wrapping 2 -> 0. Only meaningful when req != 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    logic       found;
    int         idx;
    pick  = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idx = (int'(ptr) + k) % 3;
      if (!found && req[idx]) begin
        pick  = 2'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/grant_enc.sv
// grant_enc -- one-hot grant vector to 2-bit grant code.
//   grant      in  3 : one-hot grant (bit n = requester n)
//   grant_code out 2 : 00/01/10 for requester 0/1/2, 11 for none or non-one-hot
module grant_enc
  import arb_pkg::*;
(
  input  logic [2:0] grant,
  output logic [1:0] grant_code
);

  always_comb begin
    grant_code = CODE_NONE;
    case (grant)
      3'b001:  grant_code = CODE_R0;
      3'b010:  grant_code = CODE_R1;
      3'b100:  grant_code = CODE_R2;
      default: grant_code = CODE_NONE;
    endcase
  end

endmodule

// File: rtl/rr_arb3.sv
// rr_arb3 -- three-requester round-robin arbiter with hold limit.
//   clk        in  1 : clock, all state on rising edge
//   rst        in  1 : synchronous active-high reset
//   req        in  3 : request per requester (bit n = requester n)
//   done       in  1 : release pulse from the current owner
//   grant      out 3 : registered one-hot grant
//   grant_code out 2 : encoded grant, 11 = none
//   busy       out 1 : high while a grant is held
//   timeout    out 1 : one-cycle pulse when a grant is force-released after MAX_HOLD cycles
// A grant is held until done, the owner dropping its request, or MAX_HOLD
// cycles; a one-cycle GAP with no grant always follows a release.
module rr_arb3
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] grant,
  output logic [1:0] grant_code,
  output logic       busy,
  output logic       timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_reg, state_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [2:0] grant_reg, grant_next;
  logic       timeout_reg, timeout_next;

  logic [1:0] owner_code;
  logic       owner_req;
  logic       expiry;
  logic       release_now;
  logic [1:0] pick;

  grant_enc u_enc (
    .grant      (grant_reg),
    .grant_code (owner_code)
  );

  assign owner_req   = |(req & grant_reg);
  assign expiry      = (cnt_reg == HOLD_LAST);
  assign release_now = done || !owner_req || expiry;
  assign pick        = rr_pick(req, ptr_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= 2'd0;
      cnt_reg     <= 8'd0;
      grant_reg   <= 3'b000;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      grant_reg   <= grant_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    grant_next   = grant_reg;
    timeout_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        grant_next = 3'b000;
        if (req != 3'b000) begin
          grant_next = 3'b001 << pick;
          cnt_next   = 8'd0;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (release_now) begin
          state_next   = ST_GAP;
          grant_next   = 3'b000;
          cnt_next     = 8'd0;
          ptr_next     = (owner_code == CODE_R2) ? 2'd0 : owner_code + 2'd1;
          // done wins over a coincident expiry: that is a normal release.
          timeout_next = expiry && !done;
        end else if (cnt_reg != 8'hFF) begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ST_GAP: begin
        grant_next = 3'b000;
        state_next = ST_IDLE;
      end
      default: begin
        grant_next = 3'b000;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign grant      = grant_reg;
  assign grant_code = owner_code;
  assign busy       = (state_reg == ST_BUSY);
  assign timeout    = timeout_reg;

endmodule

// File: doc/rr_arb3.md
RR_ARB3 -- requirements
Module: rr_arb3

Interface
REQ-001 Parameter MAX_HOLD, default 15, SHALL set the maximum cycles one grant is held before forced release (legal range 1..255).
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 Port req  input  3  SHALL carry requests; bit0 = requester 0, bit1 = requester 1, bit2 = requester 2.
REQ-005 Port done  input  1  SHALL be the release pulse from the current owner; ignored when no grant is active.
REQ-006 Port grant  output  3  SHALL be the one-hot grant vector (registered).
REQ-007 Port grant_code  output  2  SHALL encode grant: 00 = req0, 01 = req1, 10 = req2, 11 = none.
REQ-008 Port busy  output  1  SHALL be high while any grant is active.
REQ-009 Port timeout  output  1  SHALL pulse high for exactly one cycle when a grant is force-released by MAX_HOLD expiry.

Function
REQ-010 FSM states SHALL be IDLE, BUSY and GAP.
REQ-011 IDLE: if req != 000, the block SHALL grant the first set bit searching from priority pointer ptr upward, modulo 3, and enter BUSY; grant is visible one cycle after req is sampled.
REQ-012 BUSY: grant SHALL stay constant regardless of other req changes.
REQ-013 BUSY -> GAP SHALL occur on any of: done=1; owner's req bit = 0; hold counter = MAX_HOLD-1.
REQ-014 Simultaneous done and timeout expiry SHALL be treated as done; timeout SHALL stay 0.
REQ-015 GAP SHALL last exactly one cycle with grant = 000, grant_code = 11, busy = 0; then IDLE.
REQ-016 On leaving BUSY, ptr SHALL become (owner+1) mod 3; wrap from 2 to 0.
REQ-017 Hold counter SHALL be 8 bits, clear on entry to BUSY, increment each BUSY cycle, never wrap.
REQ-018 grant SHALL never have more than one bit set; grant_code SHALL always equal the encoding of grant.
REQ-019 busy SHALL equal (state == BUSY).
REQ-020 req changes in GAP SHALL not affect outputs until IDLE evaluates them.

Reset
REQ-021 rst = 1 at a clock edge SHALL force state = IDLE, ptr = 0, counter = 0, grant = 000, grant_code = 11, busy = 0, timeout = 0.
REQ-022 rst asserted mid-BUSY SHALL drop the grant on the next edge with no GAP cycle and no timeout pulse.
REQ-023 After rst deasserts, the first grant SHALL follow REQ-011 with ptr = 0.

Structure
REQ-024 State encodings and grant_code constants (CODE_R0 = 00, CODE_R1 = 01, CODE_R2 = 10, CODE_NONE = 11) SHALL live in shared package arb_pkg.
REQ-025 The one-hot-to-code mapping SHALL be a sub-module grant_enc (3-bit one-hot in, 2-bit code out, non-one-hot -> 11), instantiated once.
REQ-026 The FSM, pointer and counter SHALL be in rr_arb3; there SHALL be no latches and no combinational path from req to grant.

Verification
REQ-027 After rst, req = 111 -> grant = 001 / code 00 next cycle; after done, GAP, then grant = 010 / code 01; after done, GAP, then 100 / code 10; after done, GAP, then 001 (wrap).
REQ-028 req = 010 held, done never pulsed, MAX_HOLD = 4 -> grant = 010 for exactly 4 cycles, timeout = 1 for one cycle, then GAP, then grant 010 again.
REQ-029 Owner 0 drops req mid-BUSY while req2 = 1 -> grant = 000 next cycle (GAP), then grant = 100.
REQ-030 done and counter expiry on the same cycle -> release with timeout = 0.
REQ-031 rst pulsed while grant = 100 -> grant = 000, code 11 next edge; with req = 111 after reset, grant = 001.
REQ-032 done pulsed with req = 000 in IDLE -> all outputs unchanged, grant_code = 11.
